// File: rtl/noc_pkg.sv
// noc_pkg: shared types and flit helpers for the NoC crossbar blocks.
package noc_pkg;

    typedef enum logic {IDLE, REQ} in_port_state_t;

    function automatic int dest_w(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    function automatic logic [31:0] get_dest(input logic [63:0] flit, input int lsb);
        return 32'(flit >> lsb);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; full/empty come from a count register, pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/xbar_in_port.sv
// xbar_in_port: crossbar input requester; head register with FIFO bypass/prefetch,
// request FSM and starvation counter.
module xbar_in_port
    import noc_pkg::*;
#(
    parameter int PORTS       = 2,
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int DEST_LSB    = 7,
    parameter int STALL_LIMIT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_bp_o,
    output logic [WIDTH-1:0]           xbar_data_o,
    output logic [dest_w(PORTS)-1:0]   xbar_dest_o,
    output logic                       xbar_dest_en_o,
    input  logic                       xbar_ack_i,
    input  logic                       xbar_bp_i,
    output logic [$clog2(DEPTH+2)-1:0] count_o,
    output logic                       stall_o
);
    localparam int DW  = dest_w(PORTS);
    localparam int FCW = $clog2(DEPTH+1);
    localparam int CW  = $clog2(DEPTH+2);
    localparam int SW  = $clog2(STALL_LIMIT+1);

    in_port_state_t   state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d, fifo_rdata;
    logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
    logic             stall_q, stall_d;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FCW-1:0]   fifo_cnt;
    logic             push, xfer;

    assign push = in_valid & ~fifo_full;
    assign xfer = (state_q == REQ) & xbar_ack_i & ~xbar_bp_i;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (in_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (state_q == IDLE) begin
            head_d  = push ? in_data : head_q;
            state_d = push ? REQ : IDLE;
        end else if (xfer) begin
            // Prefetch from the FIFO first so order holds; bypass only when it is empty.
            fifo_pop  = ~fifo_empty;
            fifo_push = push & ~fifo_empty;
            head_d    = ~fifo_empty ? fifo_rdata : (push ? in_data : head_q);
            state_d   = (~fifo_empty | push) ? REQ : IDLE;
        end else begin
            fifo_push = push;
        end
        stall_cnt_d = (state_q == REQ && !xfer)
                    ? ((stall_cnt_q == SW'(STALL_LIMIT)) ? stall_cnt_q : stall_cnt_q + SW'(1))
                    : '0;
        stall_d     = stall_cnt_d >= SW'(STALL_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign in_bp_o        = fifo_full;
    assign xbar_dest_en_o = state_q == REQ;
    assign xbar_data_o    = head_q;
    assign xbar_dest_o    = DW'(get_dest(64'(head_q), DEST_LSB));
    assign count_o        = CW'(fifo_cnt) + CW'(state_q == REQ);
    assign stall_o        = stall_q;

endmodule

// File: tb/tb_xbar_in_port.sv
// tb_xbar_in_port: directed vector table plus hand sequences for full, stall and reset.
module tb_xbar_in_port;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_bp_o;
    logic [7:0] xbar_data_o;
    logic [0:0] xbar_dest_o;
    logic       xbar_dest_en_o;
    logic       xbar_ack_i = 1'b0;
    logic       xbar_bp_i = 1'b0;
    logic [2:0] count_o;
    logic       stall_o;

    int tests = 0;
    int fails = 0;

    xbar_in_port #(.PORTS(2), .WIDTH(8), .DEPTH(4), .DEST_LSB(7), .STALL_LIMIT(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_bp_o        (in_bp_o),
        .xbar_data_o    (xbar_data_o),
        .xbar_dest_o    (xbar_dest_o),
        .xbar_dest_en_o (xbar_dest_en_o),
        .xbar_ack_i     (xbar_ack_i),
        .xbar_bp_i      (xbar_bp_i),
        .count_o        (count_o),
        .stall_o        (stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ack;
        logic       bp;
        logic       en;
        logic       cd;
        logic [7:0] data;
        logic       dest;
        logic [2:0] cnt;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic ack, input logic bp);
        in_valid   = v;
        in_data    = d;
        xbar_ack_i = ack;
        xbar_bp_i  = bp;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, 32'(xbar_dest_en_o), 0);
        chk({tag, "_data"}, 32'(xbar_data_o), 0);
        chk({tag, "_dest"}, 32'(xbar_dest_o), 0);
        chk({tag, "_bp"}, 32'(in_bp_o), 0);
        chk({tag, "_cnt"}, 32'(count_o), 0);
        chk({tag, "_stall"}, 32'(stall_o), 0);
    endtask

    initial begin
        // v, d, ack, bp | en, check data, data, dest, count
        tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0});
        tv.push_back('{1'b1, 8'h85, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0});
        tv.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h85, 1'b1, 3'd1});
        tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        tv.push_back('{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        tv.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 3'd1});
        tv.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 3'd1});
        tv.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 3'd1});
        tv.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 3'd1});
        tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        tv.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        tv.push_back('{1'b1, 8'h92, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 3'd1});
        tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h92, 1'b1, 3'd1});
        tv.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h92, 1'b1, 3'd1});
        tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        tv.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});
        tv.push_back('{1'b1, 8'h82, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 3'd1});
        tv.push_back('{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 3'd2});
        tv.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h82, 1'b1, 3'd2});
        tv.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 3'd1});
        tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0});

        #2;
        chk_all_zero("reset_held");
        step();
        step();
        rst = 1'b0;
        step();
        chk_all_zero("reset_released");

        foreach (tv[i]) begin
            drive(tv[i].v, tv[i].d, tv[i].ack, tv[i].bp);
            chk($sformatf("vec%0d_en", i), 32'(xbar_dest_en_o), 32'(tv[i].en));
            chk($sformatf("vec%0d_cnt", i), 32'(count_o), 32'(tv[i].cnt));
            chk($sformatf("vec%0d_inbp", i), 32'(in_bp_o), 0);
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 0);
            if (tv[i].cd) begin
                chk($sformatf("vec%0d_data", i), 32'(xbar_data_o), 32'(tv[i].data));
                chk($sformatf("vec%0d_dest", i), 32'(xbar_dest_o), 32'(tv[i].dest));
            end
            step();
        end

        // Fill until back-pressure, then drain at one flit per cycle.
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 8'(k), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h06, 1'b0, 1'b0);
        chk("full_bp", 32'(in_bp_o), 1);
        chk("full_cnt", 32'(count_o), 5);
        step();
        step();
        chk("full_hold_bp", 32'(in_bp_o), 1);
        chk("full_hold_cnt", 32'(count_o), 5);
        xbar_ack_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("drain%0d_en", k), 32'(xbar_dest_en_o), 1);
            chk($sformatf("drain%0d_data", k), 32'(xbar_data_o), 32'(k));
            if (in_valid && !in_bp_o) begin
                step();
                in_valid = 1'b0;
            end else begin
                step();
            end
        end
        chk("drain_done_en", 32'(xbar_dest_en_o), 0);
        chk("drain_done_cnt", 32'(count_o), 0);
        chk("drain_done_inbp", 32'(in_bp_o), 0);

        // Starvation counter.
        drive(1'b1, 8'h05, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 18; k++) begin
            chk($sformatf("stall_c%0d", k), 32'(stall_o), 32'(k >= 15));
            step();
        end
        xbar_ack_i = 1'b1;
        chk("stall_before_grant", 32'(stall_o), 1);
        step();
        chk("stall_after_grant", 32'(stall_o), 0);
        chk("stall_after_grant_en", 32'(xbar_dest_en_o), 0);

        // Asynchronous reset mid-burst.
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        step();
        in_data = 8'hA2;
        step();
        in_data = 8'hA3;
        step();
        in_valid = 1'b0;
        chk("pre_reset_cnt", 32'(count_o), 3);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        step();
        rst = 1'b0;
        drive(1'b1, 8'h86, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        chk("post_reset_en", 32'(xbar_dest_en_o), 1);
        chk("post_reset_data", 32'(xbar_data_o), 32'h86);
        chk("post_reset_cnt", 32'(count_o), 1);
        step();
        chk("post_reset_idle_en", 32'(xbar_dest_en_o), 0);
        chk("post_reset_idle_cnt", 32'(count_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
